// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
package ram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam logic [2:0] ACC_LB  = 3'b000;
    localparam logic [2:0] ACC_LH  = 3'b001;
    localparam logic [2:0] ACC_LW  = 3'b010;
    localparam logic [2:0] ACC_LBU = 3'b100;
    localparam logic [2:0] ACC_LHU = 3'b101;

    localparam int WAIT_W = 8;

    typedef struct packed {
        logic        we;
        logic [2:0]  access;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [WAIT_W-1:0] wait_sat_inc(
        input logic [WAIT_W-1:0] cnt,
        input logic [WAIT_W-1:0] limit
    );
        return (cnt == limit) ? cnt : cnt + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner select, port 0 priority with port 1 starvation override
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              i_p0_req,
    input  logic              i_p1_req,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_grant_valid,
    output logic              o_grant_id
);

    logic w_wait_full;

    assign w_wait_full   = (i_wait_cnt == WAIT_W'(MAX_WAIT));
    assign o_grant_valid = i_p0_req | i_p1_req;
    assign o_grant_id    = (i_p1_req && (!i_p0_req || w_wait_full)) ? PORT_AUX : PORT_CPU;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serialises CPU (port 0) and aux (port 1) accesses onto one data RAM
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [2:0]  i_p0_access,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    output logic        o_p0_ack,
    output logic [31:0] o_p0_rdata,

    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [2:0]  i_p1_access,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p1_ack,
    output logic [31:0] o_p1_rdata,

    output logic        o_mem_load,
    output logic        o_mem_store,
    output logic [2:0]  o_mem_access,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [31:0]       r_rdata_q;
    logic              r_resp_id;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_grant;
    mem_req_t          w_p0_fields;
    mem_req_t          w_p1_fields;
    mem_req_t          w_sel;

    ram_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_p0_req      (i_p0_req),
        .i_p1_req      (i_p1_req),
        .i_wait_cnt    (r_wait_cnt),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_p0_fields = '{we: i_p0_we, access: i_p0_access, addr: i_p0_addr, wdata: i_p0_wdata};
    assign w_p1_fields = '{we: i_p1_we, access: i_p1_access, addr: i_p1_addr, wdata: i_p1_wdata};
    assign w_sel       = (w_grant_id == PORT_AUX) ? w_p1_fields : w_p0_fields;

    // A grant only exists outside reset, so a store cannot reach the RAM while rst is high.
    assign w_grant = (r_state == IDLE) && w_grant_valid && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_rdata_q  <= '0;
            r_resp_id  <= PORT_CPU;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_resp_id <= w_grant_id;
                r_rdata_q <= w_sel.we ? 32'h0 : i_mem_rdata;
                if (w_grant_id == PORT_AUX) begin
                    r_wait_cnt <= '0;
                end else if (i_p1_req) begin
                    r_wait_cnt <= wait_sat_inc(r_wait_cnt, WAIT_W'(MAX_WAIT));
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_mem_load   = 1'b0;
        o_mem_store  = 1'b0;
        o_mem_access = 3'b000;
        o_mem_addr   = 32'h0;
        o_mem_wdata  = 32'h0;
        o_p0_ack     = 1'b0;
        o_p1_ack     = 1'b0;
        o_p0_rdata   = 32'h0;
        o_p1_rdata   = 32'h0;

        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt  = RESP;
                    o_mem_load   = !w_sel.we;
                    o_mem_store  = w_sel.we;
                    o_mem_access = w_sel.access;
                    o_mem_addr   = w_sel.addr;
                    o_mem_wdata  = w_sel.wdata;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                // Reset landing on the response cycle swallows the ack and its data.
                if (!i_rst) begin
                    o_p0_ack   = (r_resp_id == PORT_CPU);
                    o_p1_ack   = (r_resp_id == PORT_AUX);
                    o_p0_rdata = r_rdata_q;
                    o_p1_rdata = r_rdata_q;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a byte-addressed RAM model
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [2:0]  p0_access, p1_access;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_load, mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.MAX_WAIT(MW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_p0_req     (p0_req),
        .i_p0_we      (p0_we),
        .i_p0_access  (p0_access),
        .i_p0_addr    (p0_addr),
        .i_p0_wdata   (p0_wdata),
        .o_p0_ack     (p0_ack),
        .o_p0_rdata   (p0_rdata),
        .i_p1_req     (p1_req),
        .i_p1_we      (p1_we),
        .i_p1_access  (p1_access),
        .i_p1_addr    (p1_addr),
        .i_p1_wdata   (p1_wdata),
        .o_p1_ack     (p1_ack),
        .o_p1_rdata   (p1_rdata),
        .o_mem_load   (mem_load),
        .o_mem_store  (mem_store),
        .o_mem_access (mem_access),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    // RAM model: little-endian bytes, combinational extended read, write on clock edge
    logic [7:0]  ram [0:255];
    logic [7:0]  ram_base;
    logic [31:0] ram_word;
    logic [7:0]  ram_b;
    logic [15:0] ram_h;

    always_comb begin
        ram_base = {mem_addr[7:2], 2'b00};
        ram_word = {ram[ram_base + 8'd3], ram[ram_base + 8'd2], ram[ram_base + 8'd1], ram[ram_base]};
        ram_b    = 8'(ram_word >> {mem_addr[1:0], 3'b000});
        ram_h    = 16'(ram_word >> {mem_addr[1], 4'b0000});
        case (mem_access)
            ACC_LB:  mem_rdata = {{24{ram_b[7]}}, ram_b};
            ACC_LH:  mem_rdata = {{16{ram_h[15]}}, ram_h};
            ACC_LW:  mem_rdata = ram_word;
            ACC_LBU: mem_rdata = {24'h0, ram_b};
            ACC_LHU: mem_rdata = {16'h0, ram_h};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_store) begin
            case (mem_access)
                ACC_LB: ram[mem_addr[7:0]] <= mem_wdata[7:0];
                ACC_LH: begin
                    ram[{mem_addr[7:1], 1'b0}] <= mem_wdata[7:0];
                    ram[{mem_addr[7:1], 1'b1}] <= mem_wdata[15:8];
                end
                ACC_LW: begin
                    ram[{mem_addr[7:2], 2'b00}] <= mem_wdata[7:0];
                    ram[{mem_addr[7:2], 2'b01}] <= mem_wdata[15:8];
                    ram[{mem_addr[7:2], 2'b10}] <= mem_wdata[23:16];
                    ram[{mem_addr[7:2], 2'b11}] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic        port;
        logic        we;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic pt, input logic w, input logic [2:0] a,
                                input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] e);
        vec_t v;
        v.name = n; v.port = pt; v.we = w; v.acc = a; v.addr = ad; v.wdata = wd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pt, input logic rq, input logic w, input logic [2:0] a,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (pt == PORT_CPU) begin
            p0_req = rq; p0_we = w; p0_access = a; p0_addr = ad; p0_wdata = wd;
        end else begin
            p1_req = rq; p1_we = w; p1_access = a; p1_addr = ad; p1_wdata = wd;
        end
    endtask

    // Single uncontended transaction: grant cycle checks, then ack exactly one cycle later
    task automatic txn(input vec_t v);
        int  lat;
        logic got, own_ack, other_ack;
        logic [31:0] rd;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.we, v.acc, v.addr, v.wdata);
        @(negedge clk);
        chk({v.name, "_mem_store"}, 32'(mem_store), 32'(v.we));
        chk({v.name, "_mem_addr"}, mem_addr, v.addr);
        lat = 0; got = 1'b0; own_ack = 1'b0; other_ack = 1'b0; rd = 32'h0;
        while (!got && lat < 4) begin
            @(negedge clk);
            lat++;
            own_ack   = (v.port == PORT_CPU) ? p0_ack : p1_ack;
            other_ack = (v.port == PORT_CPU) ? p1_ack : p0_ack;
            rd        = (v.port == PORT_CPU) ? p0_rdata : p1_rdata;
            got       = own_ack;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'd1);
        chk({v.name, "_rdata"}, rd, v.exp);
        chk({v.name, "_other_ack"}, 32'(other_ack), 32'd0);
        @(posedge clk); #1;
        drive(v.port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_acks"}, {30'h0, p1_ack, p0_ack}, 32'h0);
        chk({nm, "_rdata"}, p0_rdata | p1_rdata, 32'h0);
        chk({nm, "_mem_ctl"}, {30'h0, mem_store, mem_load}, 32'h0);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, gap;
        logic prev, got, a0, a1;
        logic exp_ids [6];

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rst = 1'b1;
        drive(PORT_CPU, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(PORT_AUX, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        vecs[0]  = mk("p0_sw",      PORT_CPU, 1'b1, ACC_LW,  32'h10, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk("p0_lw",      PORT_CPU, 1'b0, ACC_LW,  32'h10, 32'h0,        32'hDEADBEEF);
        vecs[2]  = mk("p1_lb",      PORT_AUX, 1'b0, ACC_LB,  32'h13, 32'h0,        32'hFFFFFFDE);
        vecs[3]  = mk("p1_lbu",     PORT_AUX, 1'b0, ACC_LBU, 32'h13, 32'h0,        32'h000000DE);
        vecs[4]  = mk("p1_sb",      PORT_AUX, 1'b1, ACC_LB,  32'h13, 32'h00000055, 32'h0);
        vecs[5]  = mk("p1_lw",      PORT_AUX, 1'b0, ACC_LW,  32'h10, 32'h0,        32'h55ADBEEF);
        vecs[6]  = mk("p0_lh",      PORT_CPU, 1'b0, ACC_LH,  32'h10, 32'h0,        32'hFFFFBEEF);
        vecs[7]  = mk("p1_lhu",     PORT_AUX, 1'b0, ACC_LHU, 32'h12, 32'h0,        32'h000055AD);
        vecs[8]  = mk("ill_load",   PORT_CPU, 1'b0, 3'b011,  32'h10, 32'h0,        32'h0);
        vecs[9]  = mk("ill_store",  PORT_CPU, 1'b1, 3'b011,  32'h10, 32'h12345678, 32'h0);
        vecs[10] = mk("ill_unchg",  PORT_AUX, 1'b0, ACC_LW,  32'h10, 32'h0,        32'h55ADBEEF);
        vecs[11] = mk("p0_sw20",    PORT_CPU, 1'b1, ACC_LW,  32'h20, 32'h11112222, 32'h0);
        vecs[12] = mk("p1_sw24",    PORT_AUX, 1'b1, ACC_LW,  32'h24, 32'h33334444, 32'h0);
        vecs[13] = mk("p0_lb11",    PORT_CPU, 1'b0, ACC_LB,  32'h11, 32'h0,        32'hFFFFFFBE);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");

        for (int i = 0; i < 14; i++) txn(vecs[i]);

        // Contention, MAX_WAIT = 2: both ports hold req every cycle
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ids = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(posedge clk); #1;
        drive(PORT_CPU, 1'b1, 1'b0, ACC_LW, 32'h20, 32'h0);
        drive(PORT_AUX, 1'b1, 1'b0, ACC_LW, 32'h24, 32'h0);
        n = 0; cyc = 0; prev = 1'b0;
        while (n < 6 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            a0 = p0_ack; a1 = p1_ack;
            if (a0 || a1) begin
                chk("cont_dual_ack", 32'(a0 & a1), 32'd0);
                chk("cont_consec_ack", 32'(prev), 32'd0);
                chk($sformatf("cont_grant%0d", n), 32'(a1), 32'(exp_ids[n]));
                chk($sformatf("cont_rdata%0d", n), a1 ? p1_rdata : p0_rdata,
                    exp_ids[n] ? 32'h33334444 : 32'h11112222);
                n++;
            end
            prev = a0 | a1;
        end
        chk("cont_ack_count", 32'(n), 32'd6);
        @(posedge clk); #1;
        drive(PORT_CPU, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(PORT_AUX, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Back-to-back: port 0 presents a new address during its ack cycle
        @(posedge clk); #1;
        drive(PORT_CPU, 1'b1, 1'b0, ACC_LW, 32'h10, 32'h0);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 4) begin
            @(negedge clk); cyc++; got = p0_ack;
        end
        chk("b2b_first_ack", 32'(got), 32'd1);
        chk("b2b_first_rdata", p0_rdata, 32'h55ADBEEF);
        p0_addr = 32'h20;
        gap = 0; got = 1'b0;
        while (!got && gap < 6) begin
            @(negedge clk); gap++; got = p0_ack;
        end
        chk("b2b_gap", 32'(gap), 32'd2);
        chk("b2b_second_rdata", p0_rdata, 32'h11112222);
        @(posedge clk); #1;
        drive(PORT_CPU, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Reset landing on the RESP cycle of a port 0 load
        txn(mk("pre_rst_sw", PORT_CPU, 1'b1, ACC_LW, 32'h30, 32'hCAFEF00D, 32'h0));
        @(posedge clk); #1;
        drive(PORT_CPU, 1'b1, 1'b0, ACC_LW, 32'h30, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(PORT_CPU, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_resp_ack", 32'(p0_ack), 32'd0);
        chk("rst_resp_rdata", p0_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        txn(mk("post_rst_lw", PORT_CPU, 1'b0, ACC_LW, 32'h30, 32'h0, 32'hCAFEF00D));

        // Reset in an IDLE cycle with a pending store: nothing reaches the RAM
        @(posedge clk); #1;
        rst = 1'b1;
        drive(PORT_CPU, 1'b1, 1'b1, ACC_LW, 32'h30, 32'h0BADBAD0);
        @(negedge clk);
        chk("rst_idle_store", 32'(mem_store), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(PORT_CPU, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        txn(mk("rst_idle_lw", PORT_CPU, 1'b0, ACC_LW, 32'h30, 32'h0, 32'hCAFEF00D));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data RAM (load/store/access/addr/data_in/data_out port) between the CPU load/store unit (port 0) and a secondary master such as a framebuffer/DMA reader (port 1). It sits between both masters and the RAM, and serialises their requests into one RAM access per transaction. It registers read data and returns a one-cycle acknowledge. Port 0 has fixed priority; a bounded-wait counter guarantees port 1 forward progress.

## Interface
- MAX_WAIT, 4: losing IDLE cycles port 1 tolerates before it is forced to win; legal range 1..255.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  request valid; held with its fields stable until the matching ack
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_access / p1_access  in  3  RAM access code (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  32  store data, right-aligned
- p0_ack / p1_ack  out  1  one-cycle pulse, transaction complete
- p0_rdata / p1_rdata  out  32  read data, valid only while the matching ack is high
- mem_load  out  1  to RAM load
- mem_store  out  1  to RAM store
- mem_access  out  3  to RAM access
- mem_addr  out  32  to RAM addr
- mem_wdata  out  32  to RAM data_in
- mem_rdata  in  32  from RAM data_out; combinational, already extended/aligned

## Operation
- FSM states: IDLE, RESP. Reset state IDLE.
- IDLE, no request: mem_load = mem_store = 0, mem_access/addr/wdata = 0. Stay in IDLE.
- IDLE, at least one request: pick the winner W.
  - W = 1 if p1_req && (!p0_req || wait_cnt == MAX_WAIT).
  - Otherwise W = 0.
- With a winner, in the same cycle:
  - Drive mem_* from port W's fields.
  - mem_store = W.we; mem_load = !W.we.
- At the closing edge of that IDLE cycle:
  - The store commits in the RAM.
  - rdata_q <= mem_rdata on a load; rdata_q <= 0 on a store.
  - resp_id <= W; FSM goes to RESP.
- RESP: assert pW_ack for exactly one cycle. Both pX_rdata are driven from rdata_q. mem_load = mem_store = 0 and the other mem_* outputs are 0. Next state is IDLE unconditionally.
- Back-to-back requests: a master may keep req high in its ack cycle with new fields. That is a new request and is sampled in the following IDLE cycle.
- wait_cnt rules (width 8):
  - Increments in each IDLE cycle where p1_req is high and port 0 wins, saturating at MAX_WAIT.
  - Clears to 0 when port 1 is granted.
  - Otherwise holds.
- Access codes pass through unchecked. An illegal code yields RAM data 0 / no byte write, and the transaction still completes with an ack.
- The address is not range-checked; the RAM wraps on its own index bits.

## Timing
- Reset values: state IDLE, wait_cnt 0, rdata_q 0, resp_id 0. All acks 0, all rdata 0, mem_load/mem_store 0.
- Latency, uncontended: request seen in IDLE cycle N, ack in cycle N+1. Store data is visible to a load issued in cycle N+2.
- Throughput: at most one transaction per 2 cycles, shared across both ports.
- Simultaneous requests: port 0 wins unless wait_cnt == MAX_WAIT. The loser's req stays pending and is arbitrated again in the next IDLE cycle.
- Worst-case port 1 wait: 2·MAX_WAIT + 2 cycles from req to ack.
- A request arriving in a RESP cycle is not seen until the next IDLE cycle.
- Reset in a RESP cycle: the ack is suppressed and the FSM returns to IDLE. A store granted before the reset stays committed; read data is discarded.
- Reset in an IDLE cycle with a request: no RAM write occurs. The grant is cancelled because mem_store is forced 0 while rst is high.

## Structure
- Package ram_arb_pkg:
  - State enum: IDLE, RESP.
  - Port id constants: PORT_CPU = 0, PORT_AUX = 1.
  - Access code constants: ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU.
- Sub-module ram_arb_pick: combinational winner select from p0_req, p1_req, wait_cnt and MAX_WAIT. Outputs grant_valid and grant_id.
- The top level holds the FSM, wait_cnt, rdata_q, the mem_* mux and the ack decode.

## Test plan
- Port 0 LW store then load: store 0xDEADBEEF to 0x10, then load LW from 0x10.
  - One ack per transaction.
  - The load returns p0_rdata = 0xDEADBEEF in its ack cycle.
- Port 1 byte ops to address 0x13 (word at 0x10 = 0xDEADBEEF):
  - LB returns 0xFFFFFFDE; LBU returns 0x000000DE.
  - Store SB 0x55 to 0x13, then LW 0x10 returns 0x55ADBEEF.
- Both ports request every cycle, MAX_WAIT = 2:
  - Grant sequence is 0, 0, 1, 0, 0, 1.
  - No two acks in the same cycle; acks never in consecutive cycles.
- Back-to-back: port 0 holds req through its ack with a new address. The second ack comes exactly 2 cycles after the first.
- Reset during the RESP of a port 0 load:
  - No p0_ack; all outputs are 0 in the cycle after reset.
  - A store granted before the reset reads back correctly afterwards.
- Illegal access code 3'b011:
  - The load acks with rdata 0.
  - The store acks and the RAM word is unchanged.
